// File: rtl/rice_param_scheduler.sv
// Issue/tag sequencer for the 15-way Rice-cost compare tree over 2^order partitions.
// Optional TOTAL_BITS_EN builds a saturating block bit total on oTotalBits.
module rice_param_scheduler #(
  parameter int MAX_ORDER = 8,
  parameter int CMP_LAT   = 4,
  parameter int SUM_W     = 32
) (
  input  logic             iClock,
  input  logic             iReset,
  input  logic             iStart,
  input  logic [3:0]       iPartOrder,
  input  logic             iCostValid,
  output logic             oCostReady,
  output logic             oCmpEnable,
  input  logic [3:0]       iCmpMinimum,
  input  logic [SUM_W-1:0] iCmpSum,
  output logic             oParamValid,
  input  logic             iParamReady,
  output logic [3:0]       oParam,
  output logic [7:0]       oPartIndex,
  output logic [SUM_W-1:0] oPartSum,
  output logic [SUM_W-1:0] oTotalBits,
  output logic             oBusy,
  output logic             oDone
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  state_t state, state_nx;

  logic [8:0]               n_parts, issue_cnt;
  logic [CMP_LAT-1:0]       vld_pipe, vld_shift;
  logic [CMP_LAT-1:0][7:0]  idx_pipe;
  logic [3:0]               ord_c;
  logic                     adv, issue, start, tags_empty_nx;

  assign ord_c      = (iPartOrder > 4'(MAX_ORDER)) ? 4'(MAX_ORDER) : iPartOrder;
  assign start      = (state == S_IDLE) && iStart;
  assign adv        = !(vld_pipe[CMP_LAT-1] && !iParamReady);
  assign oCmpEnable = adv && ((state == S_RUN) || (state == S_DRAIN));
  assign oCostReady = adv && (state == S_RUN) && (issue_cnt < n_parts);
  assign issue      = iCostValid && oCostReady;

  always_comb begin
    vld_shift[0] = issue;
    for (int i = 1; i < CMP_LAT; i++) vld_shift[i] = vld_pipe[i-1];
  end

  // Look at the tags as they will be after this edge so DONE follows the last result directly
  assign tags_empty_nx = oCmpEnable ? (vld_shift == '0) : (vld_pipe == '0);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (iStart) state_nx = S_RUN;
      S_RUN:   if (issue_cnt == n_parts) state_nx = S_DRAIN;
      S_DRAIN: if (tags_empty_nx) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state     <= S_IDLE;
      n_parts   <= '0;
      issue_cnt <= '0;
      vld_pipe  <= '0;
      idx_pipe  <= '0;
    end else begin
      state <= state_nx;
      if (start) begin
        n_parts   <= 9'd1 << ord_c;
        issue_cnt <= '0;
      end else if (issue) begin
        issue_cnt <= issue_cnt + 9'd1;
      end
      if (oCmpEnable) begin
        vld_pipe    <= vld_shift;
        idx_pipe[0] <= issue_cnt[7:0];
        for (int i = 1; i < CMP_LAT; i++) idx_pipe[i] <= idx_pipe[i-1];
      end
    end
  end

  // Tree registers are unreset; gate their outputs so idle outputs read 0
  assign oParamValid = vld_pipe[CMP_LAT-1];
  assign oPartIndex  = idx_pipe[CMP_LAT-1];
  assign oParam      = oParamValid ? iCmpMinimum : '0;
  assign oPartSum    = oParamValid ? iCmpSum : '0;
  assign oBusy       = (state != S_IDLE);
  assign oDone       = (state == S_DONE);

`ifdef TOTAL_BITS_EN
  logic [SUM_W-1:0] total;
  logic [SUM_W+1:0] sum_ext;
  assign sum_ext = {2'b00, total} + {2'b00, iCmpSum} + (SUM_W+2)'(4);

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset)                          total <= '0;
    else if (start)                      total <= '0;
    else if (oParamValid && iParamReady) total <= (sum_ext[SUM_W+1:SUM_W] != 2'b00) ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];
  end
  assign oTotalBits = total;
`else
  assign oTotalBits = '0;
`endif
endmodule

// File: tb/tb_rice_param_scheduler.sv
// Randomized bench: compare-tree model plus in-order result scoreboard for rice_param_scheduler.
module tb_rice_param_scheduler;
  localparam int CMP_LAT = 4;
  localparam int SUM_W   = 32;

  logic             iClock = 0, iReset = 1, iStart = 0, iCostValid = 0, iParamReady = 0;
  logic [3:0]       iPartOrder = 0, iCmpMinimum = 0;
  logic [SUM_W-1:0] iCmpSum = 0;
  logic             oCostReady, oCmpEnable, oParamValid, oBusy, oDone;
  logic [3:0]       oParam;
  logic [7:0]       oPartIndex;
  logic [SUM_W-1:0] oPartSum, oTotalBits;

  rice_param_scheduler #(.MAX_ORDER(8), .CMP_LAT(CMP_LAT), .SUM_W(SUM_W)) dut (
    .iClock(iClock), .iReset(iReset), .iStart(iStart), .iPartOrder(iPartOrder),
    .iCostValid(iCostValid), .oCostReady(oCostReady), .oCmpEnable(oCmpEnable),
    .iCmpMinimum(iCmpMinimum), .iCmpSum(iCmpSum), .oParamValid(oParamValid),
    .iParamReady(iParamReady), .oParam(oParam), .oPartIndex(oPartIndex),
    .oPartSum(oPartSum), .oTotalBits(oTotalBits), .oBusy(oBusy), .oDone(oDone)
  );

  always #5 iClock = ~iClock;

  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural compare tree: CMP_LAT-deep, advances only on enabled edges, no reset
  logic [3:0]       t_min [CMP_LAT];
  logic [SUM_W-1:0] t_sum [CMP_LAT];
  int en_cnt = 0;

  task automatic tick(input logic en, input logic [3:0] pm, input logic [SUM_W-1:0] ps);
    @(posedge iClock); #1;
    if (en) begin
      for (int i = CMP_LAT-1; i > 0; i--) begin
        t_min[i] = t_min[i-1];
        t_sum[i] = t_sum[i-1];
      end
      t_min[0] = pm;
      t_sum[0] = ps;
      en_cnt++;
    end
    iCmpMinimum = t_min[CMP_LAT-1];
    iCmpSum     = t_sum[CMP_LAT-1];
    @(negedge iClock);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rdy"}, oCostReady, 0);
    chk({tag, "_en"},  oCmpEnable, 0);
    chk({tag, "_vld"}, oParamValid, 0);
    chk({tag, "_par"}, oParam, 0);
    chk({tag, "_idx"}, oPartIndex, 0);
    chk({tag, "_sum"}, oPartSum, 0);
    chk({tag, "_tot"}, oTotalBits, 0);
    chk({tag, "_busy"}, oBusy, 0);
    chk({tag, "_done"}, oDone, 0);
  endtask

  typedef struct { int idx; logic [3:0] p; logic [SUM_W-1:0] s; int en0; } exp_t;

  // One block: cv_pat != 0 gives a repeating valid pattern (bit c%4), stall window forces ready low,
  // sum_sel picks directed tree sums, poke pulses iStart in RUN and on DONE, abort_at stops early.
  task automatic run_block(input int order, input int cv_pct, input int rdy_pct, input int st_lo,
                           input int st_hi, input logic [3:0] cv_pat, input int sum_sel,
                           input bit poke, input int abort_at);
    int n, issued, acc, dones, last_acc, budget;
    longint tot;
    exp_t q[$];
    exp_t e;
    bit prev_st, stall, done_seen, start_next, finished;
    logic [3:0] pp, tm;
    logic [7:0] pi;
    logic [SUM_W-1:0] ps, ts;
    logic en;
    n = 1 << ((order > 8) ? 8 : order);
    issued = 0; acc = 0; dones = 0; last_acc = -10; tot = 0;
    prev_st = 0; done_seen = 0; start_next = 0; finished = 0;
    pp = 0; pi = 0; ps = 0;
    budget = 40 * n + 100;
    iStart = 1; iPartOrder = 4'(order); iCostValid = 0; iParamReady = 1;
    #1;
    tick(oCmpEnable, 0, 0);
    iStart = 0;
    for (int c = 1; c <= budget; c++) begin
      tm = 4'($urandom);
      ts = $urandom;
      if (sum_sel == 1) ts = (issued == 0) ? 32'd100 : 32'd50;
      if (sum_sel == 2) ts = (issued == 0) ? 32'hFFFF_FFF0 : 32'h20;
      iStart      = poke && (c == 3 || start_next);
      iPartOrder  = poke ? 4'd0 : 4'(order);
      iCostValid  = (cv_pat != 0) ? cv_pat[c % 4] : ($urandom_range(99) < cv_pct);
      iParamReady = (c >= st_lo && c <= st_hi) ? 1'b0 : ($urandom_range(99) < rdy_pct);
      #1;
      if (done_seen) begin
        chk("busy_after_done", oBusy, 0);
        chk("done_one_cycle", oDone, 0);
        finished = 1;
        break;
      end
      stall = oParamValid && !iParamReady;
      if (prev_st) begin
        chk("hold_vld", oParamValid, 1);
        chk("hold_idx", oPartIndex, pi);
        chk("hold_par", oParam, pp);
        chk("hold_sum", oPartSum, ps);
      end
      if (stall) begin
        chk("stall_en", oCmpEnable, 0);
        chk("stall_rdy", oCostReady, 0);
      end
      prev_st = stall; pi = oPartIndex; pp = oParam; ps = oPartSum;
      if (oParamValid) begin
        if (q.size() == 0) chk("spurious_vld", oParamValid, 0);
        else begin
          e = q[0];
          chk("res_idx", oPartIndex, e.idx[7:0]);
          chk("res_par", oParam, e.p);
          chk("res_sum", oPartSum, e.s);
          chk("latency", en_cnt - e.en0, CMP_LAT);
          if (iParamReady) begin
            tot = tot + longint'(e.s) + 4;
            if (tot > 64'hFFFF_FFFF) tot = 64'hFFFF_FFFF;
            acc++; last_acc = c;
            void'(q.pop_front());
          end
        end
      end
      if (oDone) begin
        dones++; done_seen = 1;
        chk("done_results", acc, n);
        chk("done_gap", c - last_acc, 1);
`ifdef TOTAL_BITS_EN
        chk("total_bits", oTotalBits, tot);
`else
        chk("total_bits", oTotalBits, 0);
`endif
      end
      start_next = poke && (last_acc == c) && (acc == n);
      if (iCostValid && oCostReady) begin
        if (issued >= n) chk("over_issue", issued, n - 1);
        e.idx = issued; e.p = tm; e.s = ts; e.en0 = en_cnt;
        q.push_back(e);
        issued++;
      end
      en = oCmpEnable;
      tick(en, tm, ts);
      if (abort_at == c) begin
        finished = 1;
        break;
      end
    end
    if (!finished) chk("timeout", 0, 1);
    else if (abort_at == 0) begin
      chk("issued", issued, n);
      chk("results", acc, n);
      chk("dones", dones, 1);
    end
  endtask

  initial begin
    for (int i = 0; i < CMP_LAT; i++) begin
      t_min[i] = 4'($urandom);
      t_sum[i] = $urandom;
    end
    repeat (2) @(negedge iClock);
    #1 chk_zero("reset");
    iReset = 0;
    @(negedge iClock);
    run_block(2, 100, 100, 0, -1, 4'b0000, 0, 0, 0);
    run_block(1, 0, 100, 0, -1, 4'b0011, 0, 0, 0);
    run_block(3, 100, 100, 6, 9, 4'b0000, 0, 0, 0);
    run_block(1, 100, 100, 0, -1, 4'b0000, 1, 0, 0);
    run_block(1, 100, 100, 0, -1, 4'b0000, 2, 0, 0);
    // Abort with three partitions in flight, then a clean order-0 block
    run_block(3, 100, 100, 0, -1, 4'b0000, 0, 0, 3);
    iReset = 1;
    #1 chk_zero("abort");
    @(negedge iClock);
    iReset = 0;
    @(negedge iClock);
    run_block(0, 100, 100, 0, -1, 4'b0000, 0, 0, 0);
    run_block(12, 100, 100, 0, -1, 4'b0000, 0, 1, 0);
    for (int k = 0; k < 6; k++)
      run_block($urandom_range(5), $urandom_range(100, 30), $urandom_range(100, 30), 0, -1,
                4'b0000, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
